// File: rtl/accum_value_feeder_if.sv
// Byte-stream and issue-side signals of the accumulator feeder.
// The checksum signal exists only when ACCUM_FEEDER_CHECKSUM_EN is defined.
interface accum_value_feeder_if #(
    parameter int DEPTH = 4
);
    logic                         in_valid;
    logic [7:0]                   in_data;
    logic                         in_ready;
    logic                         enable;
    logic [31:0]                  value;
    logic                         busy;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;
`ifdef ACCUM_FEEDER_CHECKSUM_EN
    logic [31:0]                  checksum;

    modport master (
        output in_valid, in_data,
        input  in_ready, enable, value, busy, fifo_count, checksum
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, enable, value, busy, fifo_count, checksum
    );
`else
    modport master (
        output in_valid, in_data,
        input  in_ready, enable, value, busy, fifo_count
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, enable, value, busy, fifo_count
    );
`endif
endinterface

// File: rtl/accum_value_feeder.sv
// Upstream feeder for the enable/value accumulator stage.
// Packs bytes little-endian into 32-bit words, buffers them in a DEPTH-entry
// FIFO and issues each word as a one-cycle enable with value held HOLD cycles.
// Optional feature macro: ACCUM_FEEDER_CHECKSUM_EN (adds a running checksum).
module accum_value_feeder #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    accum_value_feeder_if.slave  bus
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int HCNT_W = (HOLD > 2) ? $clog2(HOLD - 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_HOLD
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [1:0]          byte_cnt;
    logic [23:0]         partial;
    logic [31:0]         mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [HCNT_W-1:0]   hold_cnt;
    logic [31:0]         value_q;
    logic                ready;
    logic                accept;
    logic                push;
    logic                pop;
    logic                load;
    logic                enable_c;
    logic                busy_c;

    // The only stall point is the 4th byte of a word arriving with no room in the FIFO
    assign ready  = !((byte_cnt == 2'd3) && (count == CNT_W'(DEPTH)));
    assign accept = bus.in_valid && ready;
    assign push   = accept && (byte_cnt == 2'd3);
    assign pop    = (state == ST_HOLD) && (hold_cnt == '0);
    assign load   = (state == ST_IDLE) && (count != '0);

    assign bus.in_ready   = ready;
    assign bus.value      = value_q;
    assign bus.fifo_count = count;
    assign bus.enable     = enable_c;
    assign bus.busy       = busy_c;

    // Byte assembler: collect bytes 0..2, the 4th byte goes straight into the FIFO
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte_cnt <= 2'd0;
            partial  <= 24'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    partial[7:0]   <= bus.in_data;
                2'd1:    partial[15:8]  <= bus.in_data;
                2'd2:    partial[23:16] <= bus.in_data;
                default: partial        <= partial;
            endcase
        end
    end

    // Word storage; contents need no reset because count gates every read
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_data, partial};
        end
    end

    // FIFO pointers and occupancy, simultaneous push and pop leave count unchanged
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issuer state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Issuer next state: start on a buffered word, one FIRE cycle, then HOLD-1 hold cycles
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (load) next_state = ST_FIRE;
            ST_FIRE: next_state = ST_HOLD;
            ST_HOLD: if (pop) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Issuer outputs decoded from the registered state
    always_comb begin
        enable_c = 1'b0;
        busy_c   = 1'b0;
        case (state)
            ST_FIRE: begin
                enable_c = 1'b1;
                busy_c   = 1'b1;
            end
            ST_HOLD: busy_c = 1'b1;
            default: begin
                enable_c = 1'b0;
                busy_c   = 1'b0;
            end
        endcase
    end

    // Value capture on entry to FIRE and countdown of the remaining hold cycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            value_q  <= 32'd0;
            hold_cnt <= '0;
        end else begin
            if (load) begin
                value_q <= mem[rd_ptr];
            end
            if (state == ST_FIRE) begin
                hold_cnt <= HCNT_W'(HOLD - 2);
            end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

`ifdef ACCUM_FEEDER_CHECKSUM_EN
    logic [31:0] checksum_q;

    assign bus.checksum = checksum_q;

    // Running sum of issued words, mirroring what the accumulator adds
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            checksum_q <= 32'd0;
        end else if (state == ST_FIRE) begin
            checksum_q <= checksum_q + value_q;
        end
    end
`endif

endmodule

// File: tb/tb_accum_value_feeder.sv
// Testbench for accum_value_feeder: two instances (default DEPTH=4/HOLD=3 and a
// small DEPTH=2/HOLD=6 one that fills up), a queue-based reference model and
// directed literal checks. Honours ACCUM_FEEDER_CHECKSUM_EN when defined.
module tb_accum_value_feeder;
    localparam int D0 = 4;
    localparam int H0 = 3;
    localparam int D1 = 2;
    localparam int H1 = 6;

    logic CLK;
    logic RST_N;

    accum_value_feeder_if #(.DEPTH(D0)) bus0 ();
    accum_value_feeder_if #(.DEPTH(D1)) bus1 ();

    accum_value_feeder #(.DEPTH(D0), .HOLD(H0)) dut0 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus0)
    );

    accum_value_feeder #(.DEPTH(D1), .HOLD(H1)) dut1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus1)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          check_on = 0;

    // Reference model state, one slot per instance
    int          m_nbytes [2];
    logic [31:0] m_partial [2];
    logic [31:0] mq [2][$];
    int          m_phase [2];
    logic [31:0] m_value [2];
    logic [31:0] m_sum [2];

    // Observed issues and in_ready-low cycles
    logic [31:0] issued [2][$];
    int          issued_cyc [2][$];
    int          low_cnt [2];

    function automatic int holdOf(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic int depthOf(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic bit modelReady(input int i);
        return !((m_nbytes[i] == 3) && (mq[i].size() == depthOf(i)));
    endfunction

    function automatic logic getReady(input int i);
        return (i == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction

    task automatic setInputs(input int i, input logic v, input logic [7:0] d);
        if (i == 0) begin
            bus0.in_valid = v;
            bus0.in_data  = d;
        end else begin
            bus1.in_valid = v;
            bus1.in_data  = d;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_nbytes[i]  = 0;
            m_partial[i] = 32'd0;
            mq[i].delete();
            m_phase[i]   = 0;
            m_value[i]   = 32'd0;
            m_sum[i]     = 32'd0;
        end
    endtask

    // One clock edge of the model: phase counts the HOLD-cycle issue window down
    task automatic modelStep();
        logic       v;
        logic [7:0] d;
        bit         acc;
        if (!RST_N) begin
            modelReset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            v   = (i == 0) ? bus0.in_valid : bus1.in_valid;
            d   = (i == 0) ? bus0.in_data : bus1.in_data;
            acc = (v === 1'b1) && modelReady(i);
            if (m_phase[i] == holdOf(i)) m_sum[i] = m_sum[i] + m_value[i];
            if (m_phase[i] == 1) begin
                void'(mq[i].pop_front());
                m_phase[i] = 0;
            end else if (m_phase[i] > 1) begin
                m_phase[i] = m_phase[i] - 1;
            end else if (mq[i].size() != 0) begin
                m_value[i] = mq[i][0];
                m_phase[i] = holdOf(i);
            end
            if (acc) begin
                if (m_nbytes[i] == 3) begin
                    mq[i].push_back({d, m_partial[i][23:0]});
                    m_nbytes[i] = 0;
                end else begin
                    m_partial[i][m_nbytes[i]*8 +: 8] = d;
                    m_nbytes[i] = m_nbytes[i] + 1;
                end
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model
    task automatic compareAll();
        logic        en;
        logic        bsy;
        logic        rdy;
        logic [31:0] val;
        int          cnt;
        for (int i = 0; i < 2; i++) begin
            en  = (i == 0) ? bus0.enable : bus1.enable;
            bsy = (i == 0) ? bus0.busy : bus1.busy;
            rdy = (i == 0) ? bus0.in_ready : bus1.in_ready;
            val = (i == 0) ? bus0.value : bus1.value;
            cnt = (i == 0) ? int'(bus0.fifo_count) : int'(bus1.fifo_count);
            checkOutput($sformatf("enable[%0d]@%0d", i, cyc), 32'(en), 32'(m_phase[i] == holdOf(i)));
            checkOutput($sformatf("busy[%0d]@%0d", i, cyc), 32'(bsy), 32'(m_phase[i] != 0));
            checkOutput($sformatf("value[%0d]@%0d", i, cyc), val, m_value[i]);
            checkOutput($sformatf("fifo_count[%0d]@%0d", i, cyc), 32'(cnt), 32'(mq[i].size()));
            checkOutput($sformatf("in_ready[%0d]@%0d", i, cyc), 32'(rdy), 32'(modelReady(i)));
`ifdef ACCUM_FEEDER_CHECKSUM_EN
            checkOutput($sformatf("checksum[%0d]@%0d", i, cyc),
                        (i == 0) ? bus0.checksum : bus1.checksum, m_sum[i]);
`endif
            if (en === 1'b1) begin
                issued[i].push_back(val);
                issued_cyc[i].push_back(cyc);
            end
            if (rdy === 1'b0) low_cnt[i]++;
        end
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic [7:0] d);
        setInputs(i, v, d);
        @(posedge CLK);
        #1;
    endtask

    // Holds a byte on the bus until the DUT handshakes it
    task automatic sendByte(input int i, input logic [7:0] d);
        logic rdy;
        int   n;
        n = 0;
        setInputs(i, 1'b1, d);
        do begin
            rdy = getReady(i);
            @(posedge CLK);
            #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) reportTimeout($sformatf("send_byte[%0d]", i));
    endtask

    task automatic waitDrain(input int i);
        int n;
        n = 0;
        while (n < 300 && (((i == 0) ? bus0.busy : bus1.busy) !== 1'b0 ||
                           ((i == 0) ? int'(bus0.fifo_count) : int'(bus1.fifo_count)) != 0)) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 300) reportTimeout($sformatf("drain[%0d]", i));
        applyStimulus(i, 1'b0, 8'h00);
    endtask

    // 24 bytes streamed with in_valid held high; checks order, spacing and stalls
    task automatic streamTest(input int i);
        logic [7:0]  b [24];
        logic [31:0] w;
        int          base;
        int          low0;
        base = issued[i].size();
        low0 = low_cnt[i];
        for (int k = 0; k < 24; k++) b[k] = 8'(k * 37 + 5 + i);
        for (int k = 0; k < 24; k++) sendByte(i, b[k]);
        setInputs(i, 1'b0, 8'h00);
        waitDrain(i);
        checkOutput($sformatf("stream[%0d]_words", i), 32'(issued[i].size() - base), 32'd6);
        for (int k = 0; k < 6 && base + k < issued[i].size(); k++) begin
            w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
            checkOutput($sformatf("stream[%0d]_word%0d", i, k), issued[i][base+k], w);
        end
        for (int k = 1; k < 6 && base + k < issued[i].size(); k++) begin
            checkOutput($sformatf("stream[%0d]_spacing%0d", i, k),
                        32'(issued_cyc[i][base+k] - issued_cyc[i][base+k-1]), 32'(holdOf(i) + 1));
        end
        if (i == 0) checkOutput("stream[0]_ready_never_low", 32'(low_cnt[0] - low0), 32'd0);
        else        checkOutput("stream[1]_ready_dropped", 32'(low_cnt[1] > low0), 32'd1);
    endtask

    initial begin
        int          base;
        logic [0:12] sv;
        logic [7:0]  sd [13];

        CLK   = 1'b0;
        RST_N = 1'b1;
        setInputs(0, 1'b0, 8'h00);
        setInputs(1, 1'b0, 8'h00);
        modelReset();
        low_cnt[0] = 0;
        low_cnt[1] = 0;

        fork
            forever #5 CLK = ~CLK;
            forever begin
                @(posedge CLK or negedge RST_N);
                modelStep();
            end
            forever begin
                @(posedge CLK);
                cyc++;
            end
            forever begin
                @(negedge CLK);
                if (check_on) compareAll();
            end
        join_none

        // Reset held with random inputs
        #2 RST_N = 1'b0;
        #1 check_on = 1'b1;
        repeat (4) begin
            setInputs(1, 1'($urandom), 8'($urandom));
            applyStimulus(0, 1'($urandom), 8'($urandom));
        end
        checkOutput("reset_enable", 32'(bus0.enable), 32'd0);
        checkOutput("reset_value", bus0.value, 32'd0);
        checkOutput("reset_busy", 32'(bus0.busy), 32'd0);
        checkOutput("reset_fifo_count", 32'(bus0.fifo_count), 32'd0);
        checkOutput("reset_in_ready", 32'(bus0.in_ready), 32'd1);
        setInputs(1, 1'b0, 8'h00);
        setInputs(0, 1'b0, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Single word with hand-computed timing
        base = issued[0].size();
        applyStimulus(0, 1'b1, 8'h78);
        applyStimulus(0, 1'b1, 8'h56);
        applyStimulus(0, 1'b1, 8'h34);
        applyStimulus(0, 1'b1, 8'h12);
        checkOutput("sw_count_after_4th", 32'(bus0.fifo_count), 32'd1);
        checkOutput("sw_enable_at_push", 32'(bus0.enable), 32'd0);
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput("sw_enable_fire", 32'(bus0.enable), 32'd1);
        checkOutput("sw_value_fire", bus0.value, 32'h12345678);
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput("sw_enable_hold1", 32'(bus0.enable), 32'd0);
        checkOutput("sw_value_hold1", bus0.value, 32'h12345678);
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput("sw_busy_hold2", 32'(bus0.busy), 32'd1);
        checkOutput("sw_value_hold2", bus0.value, 32'h12345678);
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput("sw_busy_done", 32'(bus0.busy), 32'd0);
        checkOutput("sw_count_done", 32'(bus0.fifo_count), 32'd0);
        checkOutput("sw_value_retained", bus0.value, 32'h12345678);
        checkOutput("sw_issue_count", 32'(issued[0].size() - base), 32'd1);

        // Continuous streams: default instance keeps up, small instance back-pressures
        streamTest(0);
        streamTest(1);

        // Gappy in_valid: only handshaked bytes count
        sv = 13'b1010011011011;
        sd = '{8'hAA, 8'hFF, 8'hBB, 8'hEE, 8'hDD, 8'hCC, 8'hDD,
               8'h99, 8'h01, 8'h02, 8'h77, 8'h03, 8'h04};
        base = issued[0].size();
        for (int k = 0; k < 13; k++) applyStimulus(0, sv[k], sd[k]);
        setInputs(0, 1'b0, 8'h00);
        waitDrain(0);
        checkOutput("stall_words", 32'(issued[0].size() - base), 32'd2);
        if (issued[0].size() >= base + 2) begin
            checkOutput("stall_word0", issued[0][base], 32'hDDCCBBAA);
            checkOutput("stall_word1", issued[0][base+1], 32'h04030201);
        end

        // Reset while holding a word with two bytes of the next word pending
        applyStimulus(0, 1'b1, 8'h11);
        applyStimulus(0, 1'b1, 8'h22);
        applyStimulus(0, 1'b1, 8'h33);
        applyStimulus(0, 1'b1, 8'h44);
        applyStimulus(0, 1'b1, 8'h55);
        applyStimulus(0, 1'b1, 8'h66);
        checkOutput("mid_busy_before_reset", 32'(bus0.busy), 32'd1);
        checkOutput("mid_enable_before_reset", 32'(bus0.enable), 32'd0);
        setInputs(0, 1'b0, 8'h00);
        #1 RST_N = 1'b0;
        #1;
        checkOutput("mid_reset_enable", 32'(bus0.enable), 32'd0);
        checkOutput("mid_reset_value", bus0.value, 32'd0);
        checkOutput("mid_reset_busy", 32'(bus0.busy), 32'd0);
        checkOutput("mid_reset_fifo_count", 32'(bus0.fifo_count), 32'd0);
        checkOutput("mid_reset_in_ready", 32'(bus0.in_ready), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        base = issued[0].size();
        applyStimulus(0, 1'b1, 8'h01);
        applyStimulus(0, 1'b1, 8'h00);
        applyStimulus(0, 1'b1, 8'h00);
        applyStimulus(0, 1'b1, 8'h00);
        setInputs(0, 1'b0, 8'h00);
        waitDrain(0);
        checkOutput("post_reset_words", 32'(issued[0].size() - base), 32'd1);
        if (issued[0].size() > base) checkOutput("post_reset_value", issued[0][base], 32'h00000001);

`ifdef ACCUM_FEEDER_CHECKSUM_EN
        // Checksum wraps modulo 2^32
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("cks_after_reset", bus0.checksum, 32'd0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 8'hFF);
        applyStimulus(0, 1'b1, 8'h02);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1'b1, 8'h00);
        setInputs(0, 1'b0, 8'h00);
        waitDrain(0);
        checkOutput("cks_wrapped", bus0.checksum, 32'h00000001);
`endif

        repeat (2) applyStimulus(0, 1'b0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
